riot_bus_arbiter: RTL and testbench

- Shares the single PIA/RIOT register port (stb/we/7-bit adr/8-bit data, read data registered one cycle after strobe) between the 6502 CPU and a debug/OSD host.
- CPU has absolute priority and is never stalled. Debug accesses are slotted into CPU-idle cycles.
- Debug reads of side-effecting registers (INTIM 7'h04, INSTAT 7'h05) are optionally served from shadow copies, so the host cannot clear underflow/interrupt flags.
- Sits between the CPU address decoder and the pia instance.

---
 rtl/riot_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_riot_bus_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/riot_bus_arbiter.sv
// riot_bus_arbiter: shares the PIA/RIOT register port between the 6502 CPU
// and a debug/OSD host. The CPU always wins and sees zero added latency. Debug
// accesses are slotted into CPU-idle cycles. Debug reads of the side-effecting
// timer registers can be served from shadow copies, so the host never clears
// the underflow/interrupt flags that the game code relies on.
module riot_bus_arbiter #(
   parameter int DBG_TIMEOUT    = 255,
   parameter bit DBG_RD_PROTECT = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cpu_stb_i,
   input  logic       cpu_we_i,
   input  logic [6:0] cpu_adr_i,
   input  logic [7:0] cpu_dat_i,
   output logic [7:0] cpu_dat_o,
   output logic       cpu_ack_o,
   input  logic       dbg_req_i,
   input  logic       dbg_we_i,
   input  logic [6:0] dbg_adr_i,
   input  logic [7:0] dbg_dat_i,
   output logic [7:0] dbg_dat_o,
   output logic       dbg_ack_o,
   output logic       dbg_err_o,
   output logic       dbg_busy_o,
   output logic       pia_stb_o,
   output logic       pia_we_o,
   output logic [6:0] pia_adr_o,
   output logic [7:0] pia_dat_o,
   input  logic [7:0] pia_dat_i
);

   // A timeout of 0 disables aborting, but the counter still needs one bit.
   localparam int CNT_W = (DBG_TIMEOUT > 0) ? $clog2(DBG_TIMEOUT + 1) : 1;

   localparam logic [6:0] ADR_INTIM  = 7'h04;
   localparam logic [6:0] ADR_INSTAT = 7'h05;

   typedef enum logic [1:0] {IDLE, PEND, RDCAP, DONE} state_t;

   state_t           state_q, state_d;
   logic             lat_we_q;
   logic [6:0]       lat_adr_q;
   logic [7:0]       lat_dat_q;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       shadow_intim_q;
   logic [7:0]       shadow_instat_q;
   logic [7:0]       dbg_dat_q;
   logic             cpu_ack_p1;
   logic             cpu_we_p1;
   logic [6:0]       cpu_adr_p1;

   logic             dbg_prot;
   logic             dbg_stb;
   logic             latch_en;
   logic             load_shadow;
   logic             cap_pia;

   // Blocked-cycle counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
      if (c == {CNT_W{1'b1}}) return c;
      return c + 1'b1;
   endfunction

   // A latched debug read of INTIM/INSTAT is answered from the shadow copy.
   assign dbg_prot = DBG_RD_PROTECT && !lat_we_q &&
                     ((lat_adr_q == ADR_INTIM) || (lat_adr_q == ADR_INSTAT));

   // Next-state and per-cycle control for the debug access sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      latch_en    = 1'b0;
      load_shadow = 1'b0;
      cap_pia     = 1'b0;
      dbg_stb     = 1'b0;
      case (state_q)
         IDLE: begin
            if (dbg_req_i) begin
               latch_en = 1'b1;
               cnt_d    = '0;
               err_d    = 1'b0;
               state_d  = PEND;
            end
         end
         PEND: begin
            if (dbg_prot) begin
               load_shadow = 1'b1;
               state_d     = DONE;
            end else if (!cpu_stb_i) begin
               dbg_stb = 1'b1;
               state_d = lat_we_q ? DONE : RDCAP;
            end else begin
               cnt_d = cnt_sat_inc(cnt_q);
               if ((DBG_TIMEOUT != 0) && (cnt_d == CNT_W'(DBG_TIMEOUT))) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         RDCAP: begin
            cap_pia = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer state, blocked-cycle counter and timeout flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Capture the debug request fields when the request is accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lat_we_q  <= 1'b0;
         lat_adr_q <= '0;
         lat_dat_q <= '0;
      end else if (latch_en) begin
         lat_we_q  <= dbg_we_i;
         lat_adr_q <= dbg_adr_i;
         lat_dat_q <= dbg_dat_i;
      end
   end

   // CPU strobe delayed one cycle; address/direction kept to tag the read data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cpu_ack_p1 <= 1'b0;
         cpu_we_p1  <= 1'b0;
         cpu_adr_p1 <= '0;
      end else begin
         cpu_ack_p1 <= cpu_stb_i;
         cpu_we_p1  <= cpu_we_i;
         cpu_adr_p1 <= cpu_adr_i;
      end
   end

   // Track the last value the CPU itself read from INTIM and INSTAT.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_intim_q  <= '0;
         shadow_instat_q <= '0;
      end else if (cpu_ack_p1 && !cpu_we_p1) begin
         if (cpu_adr_p1 == ADR_INTIM)  shadow_intim_q  <= pia_dat_i;
         if (cpu_adr_p1 == ADR_INSTAT) shadow_instat_q <= pia_dat_i;
      end
   end

   // Debug read data: from a shadow for protected reads, else from the pia.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dbg_dat_q <= '0;
      end else if (load_shadow) begin
         dbg_dat_q <= (lat_adr_q == ADR_INTIM) ? shadow_intim_q : shadow_instat_q;
      end else if (cap_pia) begin
         dbg_dat_q <= pia_dat_i;
      end
   end

   // Port mux: CPU first, then a pending unprotected debug access, else idle.
   always_comb begin
      pia_stb_o = 1'b0;
      pia_we_o  = 1'b0;
      pia_adr_o = '0;
      pia_dat_o = '0;
      if (cpu_stb_i) begin
         pia_stb_o = 1'b1;
         pia_we_o  = cpu_we_i;
         pia_adr_o = cpu_adr_i;
         pia_dat_o = cpu_dat_i;
      end else if (dbg_stb) begin
         pia_stb_o = 1'b1;
         pia_we_o  = lat_we_q;
         pia_adr_o = lat_adr_q;
         pia_dat_o = lat_dat_q;
      end
   end

   assign cpu_dat_o  = pia_dat_i;
   assign cpu_ack_o  = cpu_ack_p1;
   assign dbg_dat_o  = dbg_dat_q;
   assign dbg_ack_o  = (state_q == DONE);
   assign dbg_err_o  = (state_q == DONE) && err_q;
   assign dbg_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_riot_bus_arbiter.sv
// Testbench for riot_bus_arbiter: per-cycle vector table plus a hand-written
// reset-while-blocked sequence.
module tb_riot_bus_arbiter;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       cpu_stb_i, cpu_we_i;
   logic [6:0] cpu_adr_i;
   logic [7:0] cpu_dat_i;
   logic [7:0] cpu_dat_o;
   logic       cpu_ack_o;
   logic       dbg_req_i, dbg_we_i;
   logic [6:0] dbg_adr_i;
   logic [7:0] dbg_dat_i;
   logic [7:0] dbg_dat_o;
   logic       dbg_ack_o, dbg_err_o, dbg_busy_o;
   logic       pia_stb_o, pia_we_o;
   logic [6:0] pia_adr_o;
   logic [7:0] pia_dat_o;
   logic [7:0] pia_dat_i;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   riot_bus_arbiter #(.DBG_TIMEOUT(4), .DBG_RD_PROTECT(1'b1)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i), .cpu_adr_i(cpu_adr_i),
      .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o), .cpu_ack_o(cpu_ack_o),
      .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_adr_i(dbg_adr_i),
      .dbg_dat_i(dbg_dat_i), .dbg_dat_o(dbg_dat_o), .dbg_ack_o(dbg_ack_o),
      .dbg_err_o(dbg_err_o), .dbg_busy_o(dbg_busy_o),
      .pia_stb_o(pia_stb_o), .pia_we_o(pia_we_o), .pia_adr_o(pia_adr_o),
      .pia_dat_o(pia_dat_o), .pia_dat_i(pia_dat_i)
   );

   typedef struct {
      logic       rst;
      logic       cs;  logic cw; logic [6:0] ca; logic [7:0] cd;
      logic       dr;  logic dw; logic [6:0] da; logic [7:0] dd;
      logic [7:0] pd;
      logic       ps;  logic pw; logic [6:0] pa; logic [7:0] po;
      logic       cack; logic dack; logic derr; logic dbusy; logic [7:0] ddat;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst,
                      input logic cs, input logic cw, input logic [6:0] ca, input logic [7:0] cd,
                      input logic dr, input logic dw, input logic [6:0] da, input logic [7:0] dd,
                      input logic [7:0] pd,
                      input logic ps, input logic pw, input logic [6:0] pa, input logic [7:0] po,
                      input logic cack, input logic dack, input logic derr, input logic dbusy,
                      input logic [7:0] ddat);
      vec_t v;
      v.rst = rst; v.cs = cs; v.cw = cw; v.ca = ca; v.cd = cd;
      v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.pd = pd;
      v.ps = ps; v.pw = pw; v.pa = pa; v.po = po;
      v.cack = cack; v.dack = dack; v.derr = derr; v.dbusy = dbusy; v.ddat = ddat;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_i     = v.rst;
      cpu_stb_i = v.cs; cpu_we_i = v.cw; cpu_adr_i = v.ca; cpu_dat_i = v.cd;
      dbg_req_i = v.dr; dbg_we_i = v.dw; dbg_adr_i = v.da; dbg_dat_i = v.dd;
      pia_dat_i = v.pd;
   endtask

   task automatic check_row(input int row, input vec_t v);
      chk("pia_stb",  row, {7'd0, pia_stb_o},  {7'd0, v.ps});
      chk("pia_we",   row, {7'd0, pia_we_o},   {7'd0, v.pw});
      chk("pia_adr",  row, {1'b0, pia_adr_o},  {1'b0, v.pa});
      chk("pia_dat",  row, pia_dat_o,          v.po);
      chk("cpu_ack",  row, {7'd0, cpu_ack_o},  {7'd0, v.cack});
      chk("cpu_dat",  row, cpu_dat_o,          v.pd);
      chk("dbg_ack",  row, {7'd0, dbg_ack_o},  {7'd0, v.dack});
      chk("dbg_err",  row, {7'd0, dbg_err_o},  {7'd0, v.derr});
      chk("dbg_busy", row, {7'd0, dbg_busy_o}, {7'd0, v.dbusy});
      chk("dbg_dat",  row, dbg_dat_o,          v.ddat);
   endtask

   initial begin
      vec_t idle_v;
      //   rst cs cw ca     cd     dr dw da     dd     pd     | ps pw pa     po     ck dk de db ddat
      // reset state
      add(1, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h00); // 0
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h00); // 1
      // CPU write, debug idle
      add(0, 1,1,7'h14,8'h40, 0,0,7'h00,8'h00, 8'h00,  1,1,7'h14,8'h40, 0,0,0,0,8'h00); // 2
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 1,0,0,0,8'h00); // 3
      // debug write 01 <- FF, CPU idle
      add(0, 0,0,7'h00,8'h00, 1,1,7'h01,8'hFF, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h00); // 4 T
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  1,1,7'h01,8'hFF, 0,0,0,1,8'h00); // 5
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,1,0,1,8'h00); // 6
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h00); // 7
      // debug read 00, CPU owns T+1,T+2, CPU also strobes during capture
      add(0, 0,0,7'h00,8'h00, 1,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h00); // 8 T
      add(0, 1,0,7'h02,8'h00, 0,0,7'h00,8'h00, 8'h00,  1,0,7'h02,8'h00, 0,0,0,1,8'h00); // 9
      add(0, 1,0,7'h02,8'h00, 0,0,7'h00,8'h00, 8'h11,  1,0,7'h02,8'h00, 1,0,0,1,8'h00); // 10
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h22,  1,0,7'h00,8'h00, 1,0,0,1,8'h00); // 11
      add(0, 1,0,7'h02,8'h00, 0,0,7'h00,8'h00, 8'hA5,  1,0,7'h02,8'h00, 0,0,0,1,8'h00); // 12
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h33,  0,0,7'h00,8'h00, 1,1,0,1,8'hA5); // 13
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'hA5); // 14
      // CPU reads INTIM (3C), then protected debug read of INTIM
      add(0, 1,0,7'h04,8'h00, 0,0,7'h00,8'h00, 8'h00,  1,0,7'h04,8'h00, 0,0,0,0,8'hA5); // 15
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h3C,  0,0,7'h00,8'h00, 1,0,0,0,8'hA5); // 16
      add(0, 0,0,7'h00,8'h00, 1,0,7'h04,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'hA5); // 17 T
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h77,  0,0,7'h00,8'h00, 0,0,0,1,8'hA5); // 18
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h77,  0,0,7'h00,8'h00, 0,1,0,1,8'h3C); // 19
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h3C); // 20
      // timeout: CPU writes 0A continuously, debug read of 09 pending
      add(0, 1,1,7'h0A,8'h55, 1,0,7'h09,8'h00, 8'h00,  1,1,7'h0A,8'h55, 0,0,0,0,8'h3C); // 21 T
      add(0, 1,1,7'h0A,8'h55, 0,0,7'h00,8'h00, 8'h00,  1,1,7'h0A,8'h55, 1,0,0,1,8'h3C); // 22 blk1
      add(0, 1,1,7'h0A,8'h55, 0,0,7'h00,8'h00, 8'h00,  1,1,7'h0A,8'h55, 1,0,0,1,8'h3C); // 23 blk2
      add(0, 1,1,7'h0A,8'h55, 0,0,7'h00,8'h00, 8'h00,  1,1,7'h0A,8'h55, 1,0,0,1,8'h3C); // 24 blk3
      add(0, 1,1,7'h0A,8'h55, 0,0,7'h00,8'h00, 8'h00,  1,1,7'h0A,8'h55, 1,0,0,1,8'h3C); // 25 blk4
      add(0, 1,1,7'h0A,8'h55, 0,0,7'h00,8'h00, 8'h00,  1,1,7'h0A,8'h55, 1,1,1,1,8'h3C); // 26 err
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 1,0,0,0,8'h3C); // 27
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h3C); // 28
      // reset while in RDCAP, then a normal read
      add(0, 0,0,7'h00,8'h00, 1,0,7'h03,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h3C); // 29 T
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  1,0,7'h03,8'h00, 0,0,0,1,8'h3C); // 30
      add(1, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h99,  0,0,7'h00,8'h00, 0,0,0,0,8'h00); // 31 rst
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h00); // 32
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h00); // 33
      add(0, 0,0,7'h00,8'h00, 1,0,7'h06,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h00); // 34 T
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  1,0,7'h06,8'h00, 0,0,0,1,8'h00); // 35
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h5A,  0,0,7'h00,8'h00, 0,0,0,1,8'h00); // 36
      // request during DONE is ignored; next one accepted right after the ack
      add(0, 0,0,7'h00,8'h00, 1,1,7'h07,8'h12, 8'h00,  0,0,7'h00,8'h00, 0,1,0,1,8'h5A); // 37
      add(0, 0,0,7'h00,8'h00, 1,1,7'h08,8'h34, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h5A); // 38 T
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  1,1,7'h08,8'h34, 0,0,0,1,8'h5A); // 39
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,1,0,1,8'h5A); // 40
      add(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 8'h00,  0,0,7'h00,8'h00, 0,0,0,0,8'h5A); // 41

      idle_v = vq[1];
      drive(vq[0]);
      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk_i);
         #1;
         drive(vq[i]);
         @(negedge clk_i);
         check_row(i, vq[i]);
      end

      // Reset while a debug write is blocked by the CPU: access abandoned.
      @(posedge clk_i); #1;
      drive(idle_v);
      cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 7'h0C;
      dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_adr_i = 7'h0B; dbg_dat_i = 8'hAA;
      @(posedge clk_i); #1;
      dbg_req_i = 1'b0;
      @(negedge clk_i);
      chk("blk_busy", 100, {7'd0, dbg_busy_o}, 8'd1);
      chk("blk_adr",  100, {1'b0, pia_adr_o},  8'h0C);
      rst_i = 1'b1;
      #1;
      chk("rst_busy", 101, {7'd0, dbg_busy_o}, 8'd0);
      chk("rst_cack", 101, {7'd0, cpu_ack_o},  8'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0; cpu_stb_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         chk("post_rst_ack", 102 + k, {7'd0, dbg_ack_o}, 8'd0);
         chk("post_rst_stb", 102 + k, {7'd0, pia_stb_o}, 8'd0);
         @(posedge clk_i); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
